// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: 1-cycle grant latency, grant held for the whole cyc, min one idle cycle between owners.
// Backpressure is the slave's ack; non-owners simply wait. A stb-without-ack watchdog aborts a hung owner.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            gnt_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic                              s_ack_i,
  input  logic [DATA_WIDTH-1:0]             s_dat_i
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic                   own_cyc, own_stb, own_we;
  logic [ADDR_WIDTH-1:0]  own_adr;
  logic [DATA_WIDTH-1:0]  own_dat;
  logic                   found;
  logic [PW-1:0]          cand, win;

  // While granted, ptr_q is the owner index (it was set to the winner).
  assign own_cyc = m_cyc_i[ptr_q];
  assign own_stb = m_stb_i[ptr_q];
  assign own_we  = m_we_i[ptr_q];
  assign own_adr = m_adr_i[int'(ptr_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign own_dat = m_dat_i[int'(ptr_q)*DATA_WIDTH +: DATA_WIDTH];

  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;

  always_comb begin
    found = 1'b0;
    cand  = '0;
    win   = ptr_q;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = PW'((int'(ptr_q) + i) % NUM_MASTERS);
      if (!found && m_cyc_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          ptr_d      = win;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        s_cyc_o          = own_cyc;
        s_stb_o          = own_stb;
        s_we_o           = own_we;
        s_adr_o          = own_adr;
        s_dat_o          = own_dat;
        m_ack_o[ptr_q]   = s_ack_i;
        if (s_ack_i)
          cnt_d = '0;
        else if (own_stb)
          cnt_d = cnt_q + 1'b1;
        else
          cnt_d = cnt_q;
        if (!own_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (TIMEOUT > 0 && own_stb && !s_ack_i && cnt_q == LAST) begin
          // Ack on this same cycle would have taken the branch above: ack wins.
          m_err_o[ptr_q] = 1'b1;
          state_d        = ABORT;
          cnt_d          = '0;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= PW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with two masters and a 16-cycle watchdog.
module tb_wb_rr_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] m_cyc_i, m_stb_i, m_we_i;
  logic [3:0] m_adr_i;
  logic [15:0] m_dat_i;
  logic [1:0] m_ack_o, m_err_o, gnt_o;
  logic [7:0] m_dat_o;
  logic       s_cyc_o, s_stb_o, s_we_o;
  logic [1:0] s_adr_o;
  logic [7:0] s_dat_o;
  logic       s_ack_i;
  logic [7:0] s_dat_i;

  int tests = 0;
  int fails = 0;

  wb_rr_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(2), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o), .gnt_o(gnt_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] rd;
    rst_i = 1'b0; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; s_ack_i = 1'b0; s_dat_i = '0;
    step(); step();
    settle();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_scyc", s_cyc_o, 0);
    chk("rst_ack", m_ack_o, 0);
    chk("rst_err", m_err_o, 0);
    rst_i = 1'b1;

    // M0 single write
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b01;
    m_adr_i = 4'b0010; m_dat_i = 16'h0080;
    settle();
    chk("wr_gnt_latency", gnt_o, 0);
    step();
    chk("wr_gnt", gnt_o, 2'b01);
    chk("wr_scyc", s_cyc_o, 1);
    chk("wr_sstb", s_stb_o, 1);
    chk("wr_swe", s_we_o, 1);
    chk("wr_sadr", s_adr_o, 2);
    chk("wr_sdat", s_dat_o, 8'h80);
    chk("wr_noack", m_ack_o, 0);
    s_ack_i = 1'b1;
    settle();
    chk("wr_ack", m_ack_o, 2'b01);
    step();
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; s_ack_i = 1'b0;
    settle();
    chk("wr_scyc_drop", s_cyc_o, 0);
    step();
    chk("wr_gnt_idle", gnt_o, 0);

    // Tie from reset, then fairness
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    step();
    chk("tie_m0_first", gnt_o, 2'b01);
    s_ack_i = 1'b1;
    settle();
    chk("tie_ack_m0_only", m_ack_o, 2'b01);
    step();
    m_cyc_i = 2'b10; s_ack_i = 1'b0;
    step();
    chk("tie_idle_gap", gnt_o, 0);
    step();
    chk("fair_m1", gnt_o, 2'b10);
    m_cyc_i = 2'b11; s_ack_i = 1'b1;
    settle();
    chk("fair_ack_m1_only", m_ack_o, 2'b10);
    step();
    m_cyc_i = 2'b01; s_ack_i = 1'b0;
    step();
    chk("fair_idle_gap", gnt_o, 0);
    step();
    chk("fair_m0", gnt_o, 2'b01);
    m_cyc_i = '0; m_stb_i = '0;
    step(); step();

    // M1 three-beat read while M0 waits
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = '0; m_adr_i = 4'b0100;
    step();
    chk("burst_gnt", gnt_o, 2'b10);
    chk("burst_sadr", s_adr_o, 1);
    m_cyc_i = 2'b11;
    for (int k = 1; k <= 3; k++) begin
      rd = 8'(k * 8'h11);
      s_dat_i = rd; s_ack_i = 1'b1;
      settle();
      chk("burst_ack", m_ack_o, 2'b10);
      chk("burst_rdata", m_dat_o, rd);
      chk("burst_gnt_hold", gnt_o, 2'b10);
      step();
    end
    m_cyc_i = 2'b01; m_stb_i = 2'b00; s_ack_i = 1'b0;
    settle();
    chk("burst_gnt_last", gnt_o, 2'b10);
    step();
    chk("burst_idle_gap", gnt_o, 0);
    step();
    chk("burst_m0_after", gnt_o, 2'b01);

    // M0 hangs: watchdog fires on the 16th stb cycle
    m_stb_i = 2'b01;
    settle();
    for (int i = 0; i < 15; i++) begin
      chk("wd_no_err_early", m_err_o, 0);
      step();
    end
    chk("wd_err", m_err_o, 2'b01);
    step();
    chk("abort_scyc", s_cyc_o, 0);
    chk("abort_sstb", s_stb_o, 0);
    chk("abort_gnt_held", gnt_o, 2'b01);
    chk("abort_err_1cyc", m_err_o, 0);
    m_cyc_i = 2'b11; s_ack_i = 1'b1;
    settle();
    chk("abort_stale_ack", m_ack_o, 0);
    step();
    chk("abort_gnt_still", gnt_o, 2'b01);
    m_cyc_i = 2'b10; m_stb_i = 2'b00; s_ack_i = 1'b0;
    step();
    chk("abort_idle", gnt_o, 0);
    step();
    chk("abort_m1_next", gnt_o, 2'b10);

    // Reset in the middle of M1's cycle
    rst_i = 1'b0;
    step();
    chk("mid_rst_gnt", gnt_o, 0);
    chk("mid_rst_scyc", s_cyc_o, 0);
    rst_i = 1'b1;
    m_cyc_i = 2'b11; m_stb_i = 2'b01;
    step();
    chk("mid_rst_ptr", gnt_o, 2'b01);
    m_cyc_i = 2'b01;

    // Ack arrives on the watchdog's final cycle
    settle();
    for (int i = 0; i < 15; i++) step();
    s_ack_i = 1'b1;
    settle();
    chk("late_ack", m_ack_o, 2'b01);
    chk("late_ack_no_err", m_err_o, 0);
    step();
    s_ack_i = 1'b0;
    settle();
    chk("late_ack_busy", s_cyc_o, 1);
    chk("late_ack_gnt", gnt_o, 2'b01);
    step();
    chk("late_ack_cnt_clr", m_err_o, 0);
    m_cyc_i = '0; m_stb_i = '0;
    step(); step();
    chk("end_idle", gnt_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
